fetch_thread_sched: RTL and testbench

Instruction-fetch stage of the 4-thread fine-grained multithreaded pipeline. It keeps one PC per hardware thread, selects one eligible thread per cycle in round-robin order, and drives the instruction memory read port (address plus thread ID). It tags the registered memory output one cycle later and presents it to decode as a valid instruction. It also accepts branch redirects from execute and, optionally, retires threads that reach the branch-to-self halt idiom.

---
 rtl/fetch_thread_sched.sv | 151 +++++++++++++++
 tb/tb_fetch_thread_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_thread_sched.sv
// fetch_thread_sched: instruction-fetch stage for a 4-thread fine-grained
// multithreaded pipeline. It keeps one PC per thread, issues one eligible
// thread per cycle in round-robin order, and tags the registered memory read
// data one cycle later for decode. It also accepts branch redirects from
// execute.
// Optional feature: define FETCH_HALT_DETECT_EN to retire a thread once it
// delivers the branch-to-self halt idiom (HALT_INST).
module fetch_thread_sched #(
  parameter int unsigned PC_W      = 9,
  parameter logic [31:0] HALT_INST = 32'hEAFFFFFE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      thread_en,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [1:0]      br_thread,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] imem_addr,
  output logic [1:0]      imem_thread,
  input  logic [31:0]     imem_data,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [PC_W-1:0] if_pc,
  output logic [1:0]      if_thread,
  output logic [3:0]      halted
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_DETECT = 1'b1;
`else
  localparam bit HALT_DETECT = 1'b0;
`endif

  // Tag travelling alongside the one-cycle memory read.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [1:0]      thread;
  } tag_t;

  logic [PC_W-1:0] pc_q [4];
  logic [PC_W-1:0] pc_d [4];
  logic [1:0]      last_q, last_d;
  tag_t            tag_q, tag_d;
  logic [3:0]      halted_q, halted_d;
  logic [PC_W-1:0] addr_hold_q, addr_hold_d;
  logic [1:0]      thread_hold_q, thread_hold_d;

  logic [3:0] halt_now;
  logic [3:0] eligible;
  logic [1:0] sel;
  logic [1:0] cand;
  logic       found;
  logic       issue;
  logic       br_eff;
  logic       squash;

  // A redirect to a retired thread is ignored; a redirect to the thread whose
  // instruction is being presented kills that instruction.
  assign halted   = HALT_DETECT ? halted_q : 4'b0000;
  assign br_eff   = br_valid & ~halted[br_thread];
  assign squash   = br_eff & tag_q.valid & (tag_q.thread == br_thread);

  assign if_valid  = tag_q.valid & ~squash;
  assign if_inst   = imem_data;
  assign if_pc     = tag_q.pc;
  assign if_thread = tag_q.thread;

  // Halt detection: the halt instruction itself is delivered, the thread
  // drops out of the rotation immediately and is marked halted next edge.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    halt_now = 4'b0000;
    if (HALT_DETECT && if_valid && !stall && (if_inst == HALT_INST))
      halt_now[if_thread] = 1'b1;
  end

  assign eligible = thread_en & ~halted & ~halt_now;

  // Round-robin pick: first eligible thread in order last+1, last+2, ...
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    cand  = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && eligible[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign issue = ~stall & found;

  // The read port follows the issuing thread; otherwise it repeats the last
  // address so a stalled memory keeps returning the same word.
  assign imem_addr   = issue ? pc_q[sel] : addr_hold_q;
  assign imem_thread = issue ? sel       : thread_hold_q;

  // Next-state: PC advance, pointer, tag, redirect override, halt flags.
  always_comb begin
    pc_d          = pc_q;
    last_d        = last_q;
    tag_d         = tag_q;
    halted_d      = halted_q | halt_now;
    addr_hold_d   = imem_addr;
    thread_hold_d = imem_thread;

    if (issue) begin
      pc_d[sel]    = pc_q[sel] + PC_W'(1);
      last_d       = sel;
      tag_d.valid  = ~(br_eff & (br_thread == sel));
      tag_d.pc     = pc_q[sel];
      tag_d.thread = sel;
    end else if (stall) begin
      if (squash) tag_d.valid = 1'b0;
    end else begin
      tag_d.valid = 1'b0;
    end

    // Redirect wins over the increment and is accepted even while stalled.
    if (br_eff) pc_d[br_thread] = br_target;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the PC array is only four thread registers with distinct start
      // points, so it is reset explicitly like any other state.
      for (int i = 0; i < 4; i++) pc_q[i] <= PC_W'(64 * i);
      last_q        <= 2'd3;
      tag_q         <= '0;
      halted_q      <= 4'b0000;
      addr_hold_q   <= '0;
      thread_hold_q <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the next-state
      // logic above uses blocking ones.
      pc_q          <= pc_d;
      last_q        <= last_d;
      tag_q         <= tag_d;
      halted_q      <= halted_d;
      addr_hold_q   <= addr_hold_d;
      thread_hold_q <= thread_hold_d;
    end
  end

endmodule

// File: tb/tb_fetch_thread_sched.sv
// Testbench for fetch_thread_sched: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the fetch
// rules (per-thread PCs as integers, round-robin search, memory as array).
`timescale 1ns/1ps
module tb_fetch_thread_sched;
  localparam int          PC_W = 9;
  localparam logic [31:0] HALT = 32'hEAFFFFFE;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      thread_en;
  logic            stall;
  logic            br_valid;
  logic [1:0]      br_thread;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] imem_addr;
  logic [1:0]      imem_thread;
  logic [31:0]     imem_data;
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [PC_W-1:0] if_pc;
  logic [1:0]      if_thread;
  logic [3:0]      halted;

  fetch_thread_sched #(.PC_W(PC_W), .HALT_INST(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .thread_en(thread_en), .stall(stall),
    .br_valid(br_valid), .br_thread(br_thread), .br_target(br_target),
    .imem_addr(imem_addr), .imem_thread(imem_thread), .imem_data(imem_data),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_thread(if_thread), .halted(halted)
  );

  always #5 clk = ~clk;

  // Registered instruction memory: data valid one cycle after the address.
  logic [31:0] mem [512];
  always @(posedge clk) imem_data <= mem[imem_addr];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_pc [4];
  int       m_last;
  bit       m_tv;
  int       m_tpc, m_tth;
  bit [3:0] m_halted;
  int       m_addr, m_athr;

  bit       e_valid, e_issue, e_squash;
  int       e_sel, e_addr, e_athr;
  bit [3:0] e_hnow;

  task automatic model_reset();
    for (int t = 0; t < 4; t++) m_pc[t] = 64 * t;
    m_last = 3; m_tv = 0; m_tpc = 0; m_tth = 0;
    m_halted = '0; m_addr = 0; m_athr = 0;
  endtask

  task automatic model_outputs();
    bit br_ok;
    int t;
    br_ok    = br_valid && !m_halted[br_thread];
    e_squash = br_ok && m_tv && (m_tth == int'(br_thread));
    e_valid  = m_tv && !e_squash;
    e_hnow   = '0;
`ifdef FETCH_HALT_DETECT_EN
    if (e_valid && !stall && mem[m_tpc] == HALT) e_hnow[m_tth] = 1'b1;
`endif
    e_sel = -1;
    for (int k = 1; k <= 4; k++) begin
      t = (m_last + k) % 4;
      if (e_sel < 0 && thread_en[t] && !m_halted[t] && !e_hnow[t]) e_sel = t;
    end
    e_issue = !stall && (e_sel >= 0);
    e_addr  = e_issue ? m_pc[e_sel] : m_addr;
    e_athr  = e_issue ? e_sel : m_athr;
  endtask

  task automatic model_advance();
    bit br_ok;
    int old_pc;
    br_ok = br_valid && !m_halted[br_thread];
    if (e_issue) begin
      old_pc       = m_pc[e_sel];
      m_pc[e_sel]  = (old_pc + 1) % 512;
      m_last       = e_sel;
      m_tv         = !(br_ok && int'(br_thread) == e_sel);
      m_tpc        = old_pc;
      m_tth        = e_sel;
    end else if (!stall) begin
      m_tv = 0;
    end else if (e_squash) begin
      m_tv = 0;
    end
    if (br_ok) m_pc[br_thread] = int'(br_target);
    m_halted = m_halted | e_hnow;
    m_addr   = e_addr;
    m_athr   = e_athr;
  endtask

  // One clock cycle: inputs already driven after a negedge; compare, clock,
  // advance the model, return at the next negedge.
  task automatic tick();
    #1;
    if (!rst_n) model_reset();
    model_outputs();
    check("m_if_valid", 32'(if_valid), 32'(e_valid));
    if (e_valid) begin
      check("m_if_pc", 32'(if_pc), 32'(m_tpc));
      check("m_if_thread", 32'(if_thread), 32'(m_tth));
      check("m_if_inst", if_inst, mem[m_tpc]);
    end
    check("m_halted", 32'(halted), 32'(m_halted));
    check("m_imem_addr", 32'(imem_addr), 32'(e_addr));
    check("m_imem_thread", 32'(imem_thread), 32'(e_athr));
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_advance();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] en, input bit st, input bit bv,
                       input logic [1:0] bt, input logic [PC_W-1:0] tg);
    thread_en = en; stall = st; br_valid = bv; br_thread = bt; br_target = tg;
  endtask

  // Reset for one cycle, then release with the given enable mask and let
  // the first fetch issue; returns with the first slot being presented.
  task automatic do_reset(input logic [3:0] en);
    rst_n = 1'b0;
    drive(4'b0000, 0, 0, 2'd0, '0);
    tick();
    rst_n = 1'b1;
    drive(en, 0, 0, 2'd0, '0);
    tick();
  endtask

  task automatic expect_slot(input string tag, input int pc, input int thr, input logic [31:0] inst);
    check({tag, "_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_pc"}, 32'(if_pc), 32'(pc));
    check({tag, "_thread"}, 32'(if_thread), 32'(thr));
    check({tag, "_inst"}, if_inst, inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int exp_pc1 [5];
  int exp_th1 [5];
  logic [31:0] exp_in1 [5];
  int exp_pc2 [6];
  bit found;
  int guard;
  logic [3:0] en_r;

  initial begin
    for (int i = 0; i < 512; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (v == HALT) v = 32'h0;
      mem[i] = v;
    end
    mem[0]   = 32'hE3A01009;
    mem[64]  = 32'hE3A01055;
    mem[128] = 32'hE3A01000;
    mem[192] = 32'hE3A010AA;
    mem[1]   = 32'hE3A02000;
    mem[130] = 32'hE2811001;
    mem[68]  = HALT;
    mem[69]  = 32'hE1A00000;

    drive(4'b0000, 0, 0, 2'd0, '0);
    @(negedge clk);
    model_reset();
    tick();
    check("reset_if_valid", 32'(if_valid), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_imem_addr", 32'(imem_addr), 32'd0);

    // All four threads round-robin, thread 0 first.
    exp_pc1 = '{0, 64, 128, 192, 1};
    exp_th1 = '{0, 1, 2, 3, 0};
    exp_in1 = '{32'hE3A01009, 32'hE3A01055, 32'hE3A01000, 32'hE3A010AA, 32'hE3A02000};
    do_reset(4'b1111);
    for (int i = 0; i < 5; i++) begin
      expect_slot("rr4", exp_pc1[i], exp_th1[i], exp_in1[i]);
      tick();
    end

    // Threads 0 and 2 only: strict alternation.
    exp_pc2 = '{0, 128, 1, 129, 2, 130};
    do_reset(4'b0101);
    for (int i = 0; i < 6; i++) begin
      check("alt_valid", 32'(if_valid), 32'd1);
      check("alt_pc", 32'(if_pc), 32'(exp_pc2[i]));
      check("alt_thread", 32'(if_thread), (i % 2 == 0) ? 32'd0 : 32'd2);
      tick();
    end

    // Stall for three cycles mid-stream: output frozen, no lost/duplicated PC.
    do_reset(4'b0001);
    tick();
    tick();
    expect_slot("pre_stall", 2, 0, mem[2]);
    drive(4'b0001, 1, 0, 2'd0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_slot("stall_hold", 2, 0, mem[2]);
    end
    drive(4'b0001, 0, 0, 2'd0, '0);
    tick();
    expect_slot("post_stall_a", 3, 0, mem[3]);
    tick();
    expect_slot("post_stall_b", 4, 0, mem[4]);

    // Redirect thread 2 to 130 while its instruction is presented.
    do_reset(4'b0100);
    expect_slot("br_before", 128, 2, 32'hE3A01000);
    drive(4'b0100, 0, 1, 2'd2, 9'd130);
    #1;
    check("br_squash_now", 32'(if_valid), 32'd0);
    tick();
    drive(4'b0100, 0, 0, 2'd0, '0);
    check("br_squash_next", 32'(if_valid), 32'd0);
    tick();
    expect_slot("br_target", 130, 2, 32'hE2811001);

    // Thread 1 reaches the halt idiom at PC 68.
    do_reset(4'b0010);
    found = 0;
    guard = 0;
    while (!found && guard < 20) begin
      if (if_valid && if_pc == 9'd68) found = 1;
      else tick();
      guard++;
    end
    check("halt_seen", 32'(found), 32'd1);
    check("halt_inst", if_inst, HALT);
    tick();
`ifdef FETCH_HALT_DETECT_EN
    check("halt_flag", 32'(halted), 32'b0010);
    check("halt_next_slot", 32'(if_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_quiet", 32'(if_valid), 32'd0);
    end
`else
    expect_slot("nohalt_next", 69, 1, 32'hE1A00000);
    check("nohalt_flag", 32'(halted), 32'd0);
`endif

    // Thread 0 redirected to 511 wraps to 0; then asynchronous reset.
    do_reset(4'b0001);
    drive(4'b0001, 0, 1, 2'd0, 9'd511);
    #1;
    check("wrap_squash", 32'(if_valid), 32'd0);
    tick();
    drive(4'b0001, 0, 0, 2'd0, '0);
    tick();
    expect_slot("wrap_511", 511, 0, mem[511]);
    tick();
    expect_slot("wrap_0", 0, 0, mem[0]);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(if_valid), 32'd0);
    check("async_rst_halted", 32'(halted), 32'd0);
    tick();

    // Random traffic against the model, with periodic resets.
    do_reset(4'b1111);
    en_r = 4'b1111;
    for (int c = 0; c < 800; c++) begin
      if (c % 160 == 159) begin
        en_r = 4'($urandom_range(1, 15));
        do_reset(en_r);
      end else begin
        if ($urandom % 16 == 0) en_r = 4'($urandom);
        drive(en_r, ($urandom % 5) == 0, ($urandom % 6) == 0,
              2'($urandom), PC_W'($urandom));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
